// File: rtl/xif_offload_pkg.sv
// Shared types and default widths for the CV-X-IF offload initiator.
package xif_offload_pkg;

   localparam int unsigned XIF_ID_WIDTH       = 4;
   localparam int unsigned XIF_RFR_WIDTH      = 32;
   localparam int unsigned XIF_TIMEOUT_CYCLES = 1024;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      COMMIT,
      WAIT_RES,
      RESP
   } state_e;

   // Response data is held at the package width. A wider X_RFR_WIDTH needs
   // XIF_RFR_WIDTH raised to match.
   typedef struct packed {
      logic                     accepted;
      logic [XIF_RFR_WIDTH-1:0] data;
      logic                     we;
      logic                     exc;
      logic                     timeout;
   } rsp_t;

endpackage

// File: rtl/xif_offload_initiator.sv
// Core-side CV-X-IF issuer: one request -> issue -> commit -> result -> one response.
// Optional result watchdog enabled by defining XIF_INIT_TIMEOUT_EN.
module xif_offload_initiator
   import xif_offload_pkg::*;
#(
   parameter int unsigned X_ID_WIDTH     = XIF_ID_WIDTH,
   parameter int unsigned X_RFR_WIDTH    = XIF_RFR_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = XIF_TIMEOUT_CYCLES
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [31:0]            req_instr_i,
   input  logic [X_RFR_WIDTH-1:0] req_rs0_i,
   input  logic [X_RFR_WIDTH-1:0] req_rs1_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic                   rsp_accepted_o,
   output logic [X_RFR_WIDTH-1:0] rsp_data_o,
   output logic                   rsp_we_o,
   output logic                   rsp_exc_o,
   output logic                   rsp_timeout_o,
   output logic                   x_issue_valid_o,
   input  logic                   x_issue_ready_i,
   output logic [31:0]            x_issue_instr_o,
   output logic [X_ID_WIDTH-1:0]  x_issue_id_o,
   output logic [X_RFR_WIDTH-1:0] x_issue_rs0_o,
   output logic [X_RFR_WIDTH-1:0] x_issue_rs1_o,
   output logic [1:0]             x_issue_rs_valid_o,
   input  logic                   x_issue_accept_i,
   input  logic                   x_issue_writeback_i,
   output logic                   x_commit_valid_o,
   output logic [X_ID_WIDTH-1:0]  x_commit_id_o,
   output logic                   x_commit_kill_o,
   input  logic                   x_result_valid_i,
   output logic                   x_result_ready_o,
   input  logic [X_ID_WIDTH-1:0]  x_result_id_i,
   input  logic [X_RFR_WIDTH-1:0] x_result_data_i,
   input  logic                   x_result_we_i,
   input  logic                   x_result_exc_i
);

   if (TIMEOUT_CYCLES < 1) begin : g_cfg_err
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e                 state_q, state_d;
   logic [31:0]            instr_q, instr_d;
   logic [X_RFR_WIDTH-1:0] rs0_q, rs0_d, rs1_q, rs1_d;
   logic [X_ID_WIDTH-1:0]  id_q, id_d;
   logic                   acc_q, acc_d, wb_q, wb_d;
   logic                   rdy_q;
   rsp_t                   rsp_q, rsp_d;

`ifdef XIF_INIT_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // Next-state, datapath capture and handshake outputs.
   always_comb begin
      state_d          = state_q;
      instr_d          = instr_q;
      rs0_d            = rs0_q;
      rs1_d            = rs1_q;
      id_d             = id_q;
      acc_d            = acc_q;
      wb_d             = wb_q;
      rsp_d            = rsp_q;
      x_issue_valid_o  = 1'b0;
      x_commit_valid_o = 1'b0;
      x_commit_kill_o  = 1'b0;
      x_result_ready_o = 1'b0;
      rsp_valid_o      = 1'b0;
`ifdef XIF_INIT_TIMEOUT_EN
      tmo_d            = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_valid_i && rdy_q) begin
               instr_d = req_instr_i;
               rs0_d   = req_rs0_i;
               rs1_d   = req_rs1_i;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            x_issue_valid_o = 1'b1;
            if (x_issue_ready_i) begin
               acc_d   = x_issue_accept_i;
               wb_d    = x_issue_writeback_i;
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            x_commit_valid_o = 1'b1;
            x_commit_kill_o  = ~acc_q;
            if (acc_q) begin
               state_d = WAIT_RES;
            end else begin
               rsp_d   = '0;
               state_d = RESP;
            end
         end
         WAIT_RES: begin
            x_result_ready_o = 1'b1;
`ifdef XIF_INIT_TIMEOUT_EN
            tmo_d = tmo_q + TMO_W'(1);
`endif
            // Results with a foreign id are consumed and dropped.
            if (x_result_valid_i && (x_result_id_i == id_q)) begin
               rsp_d.accepted = 1'b1;
               rsp_d.data     = XIF_RFR_WIDTH'(x_result_data_i);
               // Writeback only reported when the issue response promised one.
               rsp_d.we       = x_result_we_i & wb_q;
               rsp_d.exc      = x_result_exc_i;
               rsp_d.timeout  = 1'b0;
               state_d        = RESP;
            end
`ifdef XIF_INIT_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_d          = '0;
               rsp_d.accepted = 1'b1;
               rsp_d.timeout  = 1'b1;
               state_d        = RESP;
            end
`endif
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               id_d    = id_q + X_ID_WIDTH'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; req_ready is registered so it is low in reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         instr_q <= '0;
         rs0_q   <= '0;
         rs1_q   <= '0;
         id_q    <= '0;
         acc_q   <= 1'b0;
         wb_q    <= 1'b0;
         rsp_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         rs0_q   <= rs0_d;
         rs1_q   <= rs1_d;
         id_q    <= id_d;
         acc_q   <= acc_d;
         wb_q    <= wb_d;
         rsp_q   <= rsp_d;
         rdy_q   <= (state_d == IDLE);
      end
   end

`ifdef XIF_INIT_TIMEOUT_EN
   // Watchdog counter, cleared whenever the FSM is outside WAIT_RES.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tmo_q <= '0;
      else         tmo_q <= tmo_d;
   end
   assign rsp_timeout_o = rsp_q.timeout;
`else
   assign rsp_timeout_o = 1'b0;
`endif

   assign req_ready_o        = rdy_q;
   assign x_issue_instr_o    = instr_q;
   assign x_issue_id_o       = id_q;
   assign x_issue_rs0_o      = rs0_q;
   assign x_issue_rs1_o      = rs1_q;
   assign x_issue_rs_valid_o = x_issue_valid_o ? 2'b11 : 2'b00;
   assign x_commit_id_o      = id_q;
   assign rsp_accepted_o     = rsp_q.accepted;
   assign rsp_data_o         = X_RFR_WIDTH'(rsp_q.data);
   assign rsp_we_o           = rsp_q.we;
   assign rsp_exc_o          = rsp_q.exc;

endmodule

// File: tb/tb_xif_offload_initiator.sv
// Scoreboard bench for xif_offload_initiator with a scripted coprocessor model.
module tb_xif_offload_initiator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i, req_ready_o;
   logic [31:0] req_instr_i, req_rs0_i, req_rs1_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_accepted_o, rsp_we_o, rsp_exc_o, rsp_timeout_o;
   logic [31:0] rsp_data_o;
   logic        x_issue_valid_o, x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i;
   logic [31:0] x_issue_instr_o, x_issue_rs0_o, x_issue_rs1_o;
   logic [3:0]  x_issue_id_o, x_commit_id_o, x_result_id_i;
   logic [1:0]  x_issue_rs_valid_o;
   logic        x_commit_valid_o, x_commit_kill_o;
   logic        x_result_valid_i, x_result_ready_o, x_result_we_i, x_result_exc_i;
   logic [31:0] x_result_data_i;

   always #5 clk = ~clk;

   xif_offload_initiator #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_instr_i(req_instr_i),
      .req_rs0_i(req_rs0_i), .req_rs1_i(req_rs1_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_accepted_o(rsp_accepted_o),
      .rsp_data_o(rsp_data_o), .rsp_we_o(rsp_we_o), .rsp_exc_o(rsp_exc_o), .rsp_timeout_o(rsp_timeout_o),
      .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
      .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
      .x_issue_rs0_o(x_issue_rs0_o), .x_issue_rs1_o(x_issue_rs1_o),
      .x_issue_rs_valid_o(x_issue_rs_valid_o), .x_issue_accept_i(x_issue_accept_i),
      .x_issue_writeback_i(x_issue_writeback_i),
      .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o), .x_commit_kill_o(x_commit_kill_o),
      .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
      .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
      .x_result_we_i(x_result_we_i), .x_result_exc_i(x_result_exc_i)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        acc;
      logic [31:0] data;
      logic        we;
      logic        exc;
      logic        tmo;
   } exp_t;
   exp_t sb[$];

   // Coprocessor script for the current transaction.
   bit          cp_acc, cp_wb, cp_exc, cp_stray, cp_nores;
   int          cp_idly, cp_resdly;
   logic [31:0] cp_data, cp_instr, cp_rs0, cp_rs1;
   logic [3:0]  cp_id;
   logic [3:0]  exp_id = 4'd0;
   int          commit_cnt = 0;
   int          rres_cnt = 0;

   // Activity counters for commit pulses and result_ready cycles.
   initial forever begin
      @(negedge clk);
      if (x_commit_valid_o) commit_cnt++;
      if (x_result_ready_o) rres_cnt++;
   end

   // Response monitor: compares at every rsp handshake against the scoreboard.
   initial forever begin
      exp_t e;
      @(negedge clk);
      #1;
      if (rst_n && rsp_valid_o && rsp_ready_i) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            chk("rsp_accepted", rsp_accepted_o, e.acc);
            chk("rsp_data", rsp_data_o, e.data);
            chk("rsp_we", rsp_we_o, e.we);
            chk("rsp_exc", rsp_exc_o, e.exc);
            chk("rsp_timeout", rsp_timeout_o, e.tmo);
         end
      end
   end

   task automatic chk_issue();
      chk("issue_valid", x_issue_valid_o, 1'b1);
      chk("issue_instr", x_issue_instr_o, cp_instr);
      chk("issue_rs0", x_issue_rs0_o, cp_rs0);
      chk("issue_rs1", x_issue_rs1_o, cp_rs1);
      chk("issue_id", x_issue_id_o, cp_id);
      chk("issue_rs_valid", x_issue_rs_valid_o, 2'b11);
   endtask

   // Coprocessor model: drives its inputs at the negedge after sampling.
   initial begin
      x_issue_ready_i = 0; x_issue_accept_i = 0; x_issue_writeback_i = 0;
      x_result_valid_i = 0; x_result_id_i = 0; x_result_data_i = 0;
      x_result_we_i = 0; x_result_exc_i = 0;
      forever begin
         @(negedge clk);
         if (rst_n && x_issue_valid_o) begin
            for (int k = 0; k < cp_idly; k++) begin
               chk_issue();
               @(negedge clk);
            end
            chk_issue();
            x_issue_ready_i = 1; x_issue_accept_i = cp_acc; x_issue_writeback_i = cp_wb;
            @(negedge clk);
            x_issue_ready_i = 0; x_issue_accept_i = 0; x_issue_writeback_i = 0;
            chk("commit_valid", x_commit_valid_o, 1'b1);
            chk("commit_kill", x_commit_kill_o, !cp_acc);
            chk("commit_id", x_commit_id_o, cp_id);
            if (cp_acc && !cp_nores) begin
               @(negedge clk);
               if (cp_stray) begin
                  x_result_valid_i = 1; x_result_id_i = 4'd7; x_result_data_i = 32'hDEADBEEF;
                  x_result_we_i = 1; x_result_exc_i = 1;
                  @(negedge clk);
                  x_result_valid_i = 0;
               end
               repeat (cp_resdly) @(negedge clk);
               x_result_valid_i = 1; x_result_id_i = cp_id; x_result_data_i = cp_data;
               x_result_we_i = cp_wb; x_result_exc_i = cp_exc;
               @(negedge clk);
               x_result_valid_i = 0; x_result_we_i = 0; x_result_exc_i = 0;
            end
         end
      end
   end

   task automatic send_req(input logic [31:0] instr, input logic [31:0] rs0, input logic [31:0] rs1,
                           output bit ok);
      int cyc = 0;
      while (!req_ready_o && cyc < 50) begin @(negedge clk); cyc++; end
      chk("req_ready_wait", req_ready_o, 1'b1);
      ok = req_ready_o;
      if (ok) begin
         cp_instr = instr; cp_rs0 = rs0; cp_rs1 = rs1; cp_id = exp_id;
         req_valid_i = 1; req_instr_i = instr; req_rs0_i = rs0; req_rs1_i = rs1;
         @(negedge clk);
         req_valid_i = 0;
      end
   endtask

   task automatic do_txn(input logic [31:0] instr, input logic [31:0] rs0, input logic [31:0] rs1,
                         input bit acc, input bit wb, input bit exc, input logic [31:0] res,
                         input int idly, input int rdly, input int resdly, input bit stray,
                         input bit chk_lat);
      exp_t e;
      int   cyc, c0, r0;
      bit   ok;
      cp_acc = acc; cp_wb = wb; cp_exc = exc; cp_data = res; cp_idly = idly;
      cp_resdly = resdly; cp_stray = stray; cp_nores = 0;
      e.acc = acc; e.data = acc ? res : 32'h0; e.we = acc & wb; e.exc = acc & exc; e.tmo = 0;
      c0 = commit_cnt; r0 = rres_cnt;
      sb.push_back(e);
      send_req(instr, rs0, rs1, ok);
      if (!ok) begin void'(sb.pop_back()); return; end
      if (chk_lat) chk("lat_issue", x_issue_valid_o, 1'b1);
      cyc = 1;
      while (!rsp_valid_o && cyc < 200) begin @(negedge clk); cyc++; end
      chk("rsp_valid_wait", rsp_valid_o, 1'b1);
      if (chk_lat) chk("lat_rsp", 64'(cyc), 64'd4);
      for (int k = 0; k < rdly; k++) begin
         chk("hold_valid", rsp_valid_o, 1'b1);
         chk("hold_accepted", rsp_accepted_o, e.acc);
         chk("hold_data", rsp_data_o, e.data);
         chk("hold_we", rsp_we_o, e.we);
         chk("hold_exc", rsp_exc_o, e.exc);
         @(negedge clk);
      end
      rsp_ready_i = 1;
      @(negedge clk);
      rsp_ready_i = 0;
      chk("rsp_dropped", rsp_valid_o, 1'b0);
      chk("one_commit", 64'(commit_cnt - c0), 64'd1);
      if (!acc) chk("no_result_phase", 64'(rres_cnt - r0), 64'd0);
      exp_id = exp_id + 4'd1;
   endtask

   initial begin
      bit ok;
      int cyc;
      rst_n = 0; req_valid_i = 0; req_instr_i = 0; req_rs0_i = 0; req_rs1_i = 0; rsp_ready_i = 0;
      cp_acc = 0; cp_wb = 0; cp_exc = 0; cp_stray = 0; cp_nores = 0;
      cp_idly = 0; cp_resdly = 0; cp_data = 0; cp_instr = 0; cp_rs0 = 0; cp_rs1 = 0; cp_id = 0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready_o, 1'b0);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_issue_valid", x_issue_valid_o, 1'b0);
      chk("rst_commit_valid", x_commit_valid_o, 1'b0);
      chk("rst_result_ready", x_result_ready_o, 1'b0);
      chk("rst_rsp_data", rsp_data_o, 32'h0);
      chk("rst_issue_id", x_issue_id_o, 4'h0);
      rst_n = 1;
      @(negedge clk);
      chk("idle_req_ready", req_ready_o, 1'b1);

      // Accept path, zero-wait partner: 1.0 + 2.0 = 3.0
      do_txn(32'h0020F053, 32'h3F800000, 32'h40000000, 1, 1, 0, 32'h40400000, 0, 0, 0, 0, 1);
      // Reject path
      do_txn(32'h0020F053, 32'h11111111, 32'h22222222, 0, 0, 0, 32'hAAAAAAAA, 0, 0, 0, 0, 0);
      // Issue and response backpressure, exception reported
      do_txn(32'h1234F053, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 1, 1, 32'h12345678, 5, 3, 1, 0, 0);
      // Stray result with id 7 ahead of the real one
      do_txn(32'h0000F053, 32'h00000003, 32'h00000004, 1, 1, 0, 32'hCAFEF00D, 0, 1, 2, 1, 0);
      // Ids 4..15
      for (int i = 4; i < 16; i++)
         do_txn(32'h0020F053, 32'(i), 32'(i + 1), 1, i[0], 0, 32'h100 * i, i % 3, i % 2, i % 4, 0, 0);
      // 17th transaction wraps to id 0
      chk("wrap_id", x_issue_id_o, 4'h0);
      do_txn(32'h0171F053, 32'h17171717, 32'h71717171, 1, 1, 0, 32'h17170000, 0, 0, 0, 0, 0);

`ifdef XIF_INIT_TIMEOUT_EN
      begin
         exp_t e;
         cp_acc = 1; cp_wb = 1; cp_exc = 0; cp_idly = 0; cp_stray = 0; cp_nores = 1;
         e.acc = 1; e.data = 0; e.we = 0; e.exc = 0; e.tmo = 1;
         sb.push_back(e);
         send_req(32'h0020F053, 32'h1, 32'h2, ok);
         cyc = 0;
         while (!x_result_ready_o && cyc < 20) begin @(negedge clk); cyc++; end
         chk("tmo_wait_res", x_result_ready_o, 1'b1);
         cyc = 0;
         while (!rsp_valid_o && cyc < 50) begin @(negedge clk); cyc++; end
         chk("tmo_latency", 64'(cyc), 64'd8);
         rsp_ready_i = 1;
         @(negedge clk);
         rsp_ready_i = 0;
         exp_id = exp_id + 4'd1;
      end
`endif

      // Reset while waiting for a result
      cp_acc = 1; cp_wb = 1; cp_idly = 0; cp_stray = 0; cp_nores = 1;
      send_req(32'h0020F053, 32'h5, 32'h6, ok);
      cyc = 0;
      while (!x_result_ready_o && cyc < 20) begin @(negedge clk); cyc++; end
      chk("mid_wait_res", x_result_ready_o, 1'b1);
      rst_n = 0;
      #1;
      chk("mrst_result_ready", x_result_ready_o, 1'b0);
      chk("mrst_req_ready", req_ready_o, 1'b0);
      chk("mrst_issue_valid", x_issue_valid_o, 1'b0);
      chk("mrst_rsp_valid", rsp_valid_o, 1'b0);
      chk("mrst_issue_instr", x_issue_instr_o, 32'h0);
      chk("mrst_commit_id", x_commit_id_o, 4'h0);
      @(negedge clk);
      rst_n = 1;
      exp_id = 4'd0;
      do_txn(32'h0020F053, 32'h3F800000, 32'h40000000, 1, 1, 0, 32'h40400000, 0, 0, 0, 0, 1);

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
